// File: rtl/sonar_array_ctrl.sv
// sonar_array_ctrl: Wishbone front-end for an array of sonar channels,
// with mic-clock, PDM/PCM strobe generation and maskable interrupts.
module sonar_array_ctrl #(
    parameter int         N_CH     = 8,
    parameter int         CH_AW    = 4,
    parameter int         DW       = 16,
    parameter int         PRE_W    = 10,
    parameter int         DIV_W    = 4,
    parameter int         ACK_TMO  = 15,
    parameter logic [3:0] BASE_NIB = 4'h3
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [N_CH-1:0]    ch_valid_o,
    output logic [CH_AW-1:0]   ch_adr_o,
    output logic [DW-1:0]      ch_dat_o,
    output logic               ch_strb_o,
    input  logic [N_CH-1:0]    ch_ack_i,
    input  logic [N_CH*DW-1:0] ch_dat_i,
    input  logic [N_CH-1:0]    ch_cmp_i,
    output logic               ch_clear_o,
    output logic               mclk_o,
    output logic               ce_pdm_o,
    output logic               ce_pcm_o,
    output logic               irq_o
);

    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW  = $clog2(ACK_TMO + 1);
    localparam int XW  = 32 - DW;

    localparam logic [N_CH-1:0]  CH_ONE   = 1;
    localparam logic [DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [DIV_W-1:0] DIV_MIN  = 2;
    localparam logic [DIV_W-1:0] DIV_RST  = 5;
    localparam logic [PRE_W-1:0] PRE_ONE  = 1;
    localparam logic [PRE_W-1:0] PRE_RST  = 49;
    localparam logic [TW-1:0]    TMO_LAST = TW'(ACK_TMO - 1);
    localparam logic [TW-1:0]    TMO_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CH_WAIT,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [9:0]        w_word;
    logic [9:0]        w_chsel;
    logic              w_hit;
    logic              w_is_csr;
    logic              w_is_ch;
    logic [31:0]       w_bmask;
    logic [31:0]       w_csr_rdat;
    logic [DW-1:0]     w_ch_rd;
    logic              w_go_csr;
    logic              w_go_ch;
    logic              w_ch_done;
    logic              w_ch_tmo;
    logic              w_abort;

    logic              r_ack;
    logic [31:0]       r_dat;
    logic [N_CH-1:0]   r_valid;
    logic [CHW-1:0]    r_ch;
    logic [CH_AW-1:0]  r_ch_adr;
    logic [DW-1:0]     r_ch_dat;
    logic              r_ch_strb;
    logic [TW-1:0]     r_tmo_cnt;

    logic [PRE_W-1:0]  r_pre;
    logic [N_CH-1:0]   r_pend;
    logic [N_CH-1:0]   r_mask;
    logic              r_mask_tmo;
    logic [DIV_W-1:0]  r_div;
    logic              r_tmo_flag;
    logic              r_clear;
    logic [N_CH-1:0]   r_cmp;
    logic [N_CH-1:0]   r_cmp_q;
    logic              r_irq;

    logic              w_csr_we;
    logic              w_we_sts;
    logic              w_we_pre;
    logic              w_we_pend;
    logic              w_we_mask;
    logic              w_we_div;
    logic              w_we_ctrl;
    logic [DIV_W-1:0]  w_div_new;
    logic [N_CH-1:0]   w_pclr;
    logic [N_CH-1:0]   w_rise;

    logic [DIV_W-1:0]  r_mcnt;
    logic [DIV_W-1:0]  r_div_act;
    logic              r_mclk;
    logic              r_pdm;
    logic              w_mwrap;
    logic [PRE_W-1:0]  r_pcnt;
    logic              r_pcm;
    logic              w_pfire;

    logic              w_unused;

    assign w_word   = wbs_adr_i[11:2];
    assign w_chsel  = (w_word - 10'd16) >> CH_AW;
    assign w_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB);
    assign w_is_csr = (w_word < 10'd16);
    assign w_is_ch  = !w_is_csr && (w_chsel < 10'(N_CH));
    assign w_bmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_ch_rd  = ch_dat_i[r_ch*DW +: DW];
    assign w_unused = &{1'b0, wbs_adr_i[27:12], wbs_adr_i[1:0], wbs_dat_i};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_go_csr   = 1'b0;
        w_go_ch    = 1'b0;
        w_ch_done  = 1'b0;
        w_ch_tmo   = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    if (w_is_ch) begin
                        w_state_nx = S_CH_WAIT;
                        w_go_ch    = 1'b1;
                    end else begin
                        w_state_nx = S_ACK;
                        w_go_csr   = 1'b1;
                    end
                end
            end
            S_CH_WAIT: begin
                if (!wbs_cyc_i) begin
                    w_state_nx = S_IDLE;
                    w_abort    = 1'b1;
                end else if (ch_ack_i[r_ch]) begin
                    w_state_nx = S_ACK;
                    w_ch_done  = 1'b1;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nx = S_ACK;
                    w_ch_tmo   = 1'b1;
                end
            end
            S_ACK:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_csr_rdat = '0;
        if (w_is_csr) begin
            case (w_word[3:0])
                4'd0: begin
                    w_csr_rdat[N_CH-1:0] = r_cmp;
                    w_csr_rdat[31]       = r_tmo_flag;
                end
                4'd1: w_csr_rdat[PRE_W-1:0] = r_pre;
                4'd2: w_csr_rdat[N_CH-1:0]  = r_pend;
                4'd3: begin
                    w_csr_rdat[N_CH-1:0] = r_mask;
                    w_csr_rdat[31]       = r_mask_tmo;
                end
                4'd4: w_csr_rdat[DIV_W-1:0] = r_div;
                default: w_csr_rdat = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_valid   <= '0;
            r_ch      <= '0;
            r_ch_adr  <= '0;
            r_ch_dat  <= '0;
            r_ch_strb <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_ack <= (w_state_nx == S_ACK);
            if (w_go_csr) begin
                r_dat <= w_csr_rdat;
            end else if (w_ch_done) begin
                r_dat <= {{XW{w_ch_rd[DW-1]}}, w_ch_rd};
            end else if (w_ch_tmo) begin
                r_dat <= '0;
            end
            if (w_go_ch) begin
                r_valid   <= CH_ONE << w_chsel[CHW-1:0];
                r_ch      <= w_chsel[CHW-1:0];
                r_ch_adr  <= w_word[CH_AW-1:0];
                r_ch_dat  <= {wbs_dat_i[31], wbs_dat_i[DW-2:0]};
                r_ch_strb <= wbs_we_i & wbs_sel_i[0];
                r_tmo_cnt <= '0;
            end else if (w_ch_done || w_ch_tmo || w_abort) begin
                r_valid <= '0;
            end else if (r_state == S_CH_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
            end
        end
    end

    assign w_csr_we  = w_go_csr & wbs_we_i & w_is_csr;
    assign w_we_sts  = w_csr_we && (w_word[3:0] == 4'd0);
    assign w_we_pre  = w_csr_we && (w_word[3:0] == 4'd1);
    assign w_we_pend = w_csr_we && (w_word[3:0] == 4'd2);
    assign w_we_mask = w_csr_we && (w_word[3:0] == 4'd3);
    assign w_we_div  = w_csr_we && (w_word[3:0] == 4'd4);
    assign w_we_ctrl = w_csr_we && (w_word[3:0] == 4'd5);

    assign w_div_new = (r_div & ~w_bmask[DIV_W-1:0])
                     | (wbs_dat_i[DIV_W-1:0] & w_bmask[DIV_W-1:0]);
    assign w_pclr    = w_we_pend ? (wbs_dat_i[N_CH-1:0] & w_bmask[N_CH-1:0])
                                 : '0;
    assign w_rise    = r_cmp & ~r_cmp_q;

    // A fresh detection edge survives a same-cycle W1C of its bit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_pre      <= PRE_RST;
            r_pend     <= '0;
            r_mask     <= '0;
            r_mask_tmo <= 1'b0;
            r_div      <= DIV_RST;
            r_tmo_flag <= 1'b0;
            r_clear    <= 1'b0;
            r_cmp      <= '0;
            r_cmp_q    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_cmp   <= ch_cmp_i;
            r_cmp_q <= r_cmp;
            r_pend  <= (r_pend & ~w_pclr) | w_rise;
            r_clear <= w_we_ctrl & wbs_dat_i[0] & wbs_sel_i[0];
            r_irq   <= (|(r_pend & r_mask)) | (r_tmo_flag & r_mask_tmo);
            if (w_ch_tmo) begin
                r_tmo_flag <= 1'b1;
            end else if (w_we_sts && wbs_sel_i[3] && wbs_dat_i[31]) begin
                r_tmo_flag <= 1'b0;
            end
            if (w_we_pre) begin
                r_pre <= (r_pre & ~w_bmask[PRE_W-1:0])
                       | (wbs_dat_i[PRE_W-1:0] & w_bmask[PRE_W-1:0]);
            end
            if (w_we_mask) begin
                r_mask <= (r_mask & ~w_bmask[N_CH-1:0])
                        | (wbs_dat_i[N_CH-1:0] & w_bmask[N_CH-1:0]);
                if (wbs_sel_i[3]) begin
                    r_mask_tmo <= wbs_dat_i[31];
                end
            end
            if (w_we_div) begin
                r_div <= (w_div_new < DIV_MIN) ? DIV_MIN : w_div_new;
            end
        end
    end

    assign w_mwrap = (r_mcnt >= (r_div_act - DIV_ONE));
    assign w_pfire = (r_pcnt >= r_pre);

    // Divider changes are deferred to the wrap so no mclk phase is truncated.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_mcnt    <= '0;
            r_div_act <= DIV_RST;
            r_mclk    <= 1'b0;
            r_pdm     <= 1'b0;
            r_pcnt    <= '0;
            r_pcm     <= 1'b0;
        end else begin
            r_mcnt <= w_mwrap ? '0 : (r_mcnt + DIV_ONE);
            if (w_mwrap) begin
                r_div_act <= r_div;
            end
            r_mclk <= (r_mcnt < (r_div_act >> 1));
            r_pdm  <= (r_mcnt == DIV_ONE);
            r_pcnt <= w_pfire ? '0 : (r_pcnt + PRE_ONE);
            r_pcm  <= w_pfire;
        end
    end

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;
    assign ch_valid_o = r_valid;
    assign ch_adr_o   = r_ch_adr;
    assign ch_dat_o   = r_ch_dat;
    assign ch_strb_o  = r_ch_strb;
    assign ch_clear_o = r_clear;
    assign mclk_o     = r_mclk;
    assign ce_pdm_o   = r_pdm;
    assign ce_pcm_o   = r_pcm;
    assign irq_o      = r_irq;

endmodule
